// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Multicycle MIPS main controller. It is a Moore FSM that sequences the
// fetch, decode, memory, execute, branch and jump steps. The outputs depend
// on the state register. The exceptions are ALUControl, which in EXECUTE is
// decoded from Funct, and PCEn, which in BRANCH follows Zero.
//
// Optional feature macro: MIPS_MUL_EN. When it is defined, Funct 011000 is a
// legal MUL (ALUControl 101). When it is undefined, Funct 011000 is treated
// as an illegal Funct.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (forces FETCH)
//   Op         in   [5:0] instruction[31:26]
//   Funct      in   [5:0] instruction[5:0]
//   Zero       in   ALU zero flag (same cycle)
//   ALUControl out  [2:0] ALU opcode
//   ALUSrcA    out  0=PC, 1=register A
//   ALUSrcB    out  [1:0] 00=B, 01=4, 10=signimm, 11=signimm<<2
//   IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg  out  strobes/selects
//   PCSrc      out  [1:0] 00=ALUResult, 01=ALUOut, 10=jump target
//   PCEn       out  PC register enable
//   InstrDone  out  pulse in the final state of each instruction
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_reg, state_next;
  // Set when FETCH is entered because an illegal Op or Funct aborted the
  // instruction. That FETCH is then the final cycle of the aborted
  // instruction, so it raises InstrDone.
  logic   abort_done_reg, abort_done_next;

  logic [2:0] funct_alu;
  logic       funct_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FETCH;
      abort_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      abort_done_reg <= abort_done_next;
    end
  end

  // R-type function decode. An unknown Funct falls back to ADD and is
  // marked illegal so that EXECUTE aborts without a register write.
  always_comb begin
    funct_alu   = 3'b010;
    funct_legal = 1'b0;
    case (Funct)
      6'b100000: begin funct_alu = 3'b010; funct_legal = 1'b1; end
      6'b100010: begin funct_alu = 3'b100; funct_legal = 1'b1; end
      6'b100100: begin funct_alu = 3'b000; funct_legal = 1'b1; end
      6'b100101: begin funct_alu = 3'b001; funct_legal = 1'b1; end
      6'b101010: begin funct_alu = 3'b110; funct_legal = 1'b1; end
`ifdef MIPS_MUL_EN
      6'b011000: begin funct_alu = 3'b101; funct_legal = 1'b1; end
`endif
      default:   begin funct_alu = 3'b010; funct_legal = 1'b0; end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next      = FETCH;
    abort_done_next = 1'b0;
    case (state_reg)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default: begin
            state_next      = FETCH;
            abort_done_next = 1'b1;
          end
        endcase
      end
      MEMADR:   state_next = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      EXECUTE: begin
        if (funct_legal) begin
          state_next = ALUWB;
        end else begin
          state_next      = FETCH;
          abort_done_next = 1'b1;
        end
      end
      ADDIEXEC: state_next = ADDIWB;
      default:  state_next = FETCH;  // MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP
    endcase
  end

  // Output logic. Every output defaults to 0 and each state raises only
  // what it needs.
  always_comb begin
    ALUControl = 3'b000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    InstrDone  = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = 3'b010;
        PCEn       = 1'b1;
        InstrDone  = abort_done_reg;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB    = 2'b11;
        ALUControl = 3'b010;
      end
      MEMADR, ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b010;
      end
      MEMRD: IorD = 1'b1;
      MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b100;
        PCSrc      = 2'b01;
        PCEn       = Zero;
        InstrDone  = 1'b1;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
